// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered read data and read-valid strobe.
// Ports: clk, rstn, wr_en, rd_en, data_in -> fifo_empty, fifo_full, rd_vld, data_out.
module sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_WIDTH = $clog2(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  fifo_empty,
    output logic                  fifo_full,
    output logic                  rd_vld,
    output logic [DATA_WIDTH-1:0] data_out
);

    localparam logic [ADDR_WIDTH:0] PTR_ONE = 1;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [ADDR_WIDTH:0]   wp;
    logic [ADDR_WIDTH:0]   rp;
    logic                  wr_acc;
    logic                  rd_acc;

    // Extra MSB on each pointer tells full (laps differ) from empty.
    assign fifo_empty = (wp == rp);
    assign fifo_full  = (wp[ADDR_WIDTH-1:0] == rp[ADDR_WIDTH-1:0])
                     && (wp[ADDR_WIDTH] != rp[ADDR_WIDTH]);

    assign wr_acc = wr_en && !fifo_full;
    assign rd_acc = rd_en && !fifo_empty;

    // Storage has no reset; pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wp[ADDR_WIDTH-1:0]] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wp <= '0;
        end else if (wr_acc) begin
            wp <= wp + PTR_ONE;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rp       <= '0;
            rd_vld   <= 1'b0;
            data_out <= '0;
        end else if (rd_acc) begin
            rp       <= rp + PTR_ONE;
            rd_vld   <= 1'b1;
            data_out <= mem[rp[ADDR_WIDTH-1:0]];
        end else begin
            rd_vld   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: directed self-checking bench for sync_fifo.
// Drives inputs on the falling edge and samples outputs on the next falling edge.
module tb_sync_fifo;

    logic       clk;
    logic       rstn;
    logic       wr_en;
    logic       rd_en;
    logic [7:0] data_in;
    logic       fifo_empty;
    logic       fifo_full;
    logic       rd_vld;
    logic [7:0] data_out;

    int checks;
    int errors;

    sync_fifo #(
        .DATA_WIDTH(8),
        .FIFO_DEPTH(8),
        .ADDR_WIDTH(3)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .wr_en     (wr_en),
        .rd_en     (rd_en),
        .data_in   (data_in),
        .fifo_empty(fifo_empty),
        .fifo_full (fifo_full),
        .rd_vld    (rd_vld),
        .data_out  (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rstn = 1'b0; wr_en = 1'b0; rd_en = 1'b0; data_in = 8'h00;
        @(negedge clk);
        checks++;
        if (fifo_empty !== 1'b1) begin
            errors++; $display("FAIL reset_empty got %b want 1", fifo_empty);
        end
        checks++;
        if (fifo_full !== 1'b0) begin
            errors++; $display("FAIL reset_full got %b want 0", fifo_full);
        end
        checks++;
        if (rd_vld !== 1'b0) begin
            errors++; $display("FAIL reset_rd_vld got %b want 0", rd_vld);
        end
        checks++;
        if (data_out !== 8'h00) begin
            errors++; $display("FAIL reset_data got %h want 00", data_out);
        end
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_fill(input logic [7:0] base);
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; data_in = base + 8'(i);
            step();
            checks++;
            if (fifo_empty !== 1'b0) begin
                errors++; $display("FAIL fill_empty[%0d] got %b want 0", i, fifo_empty);
            end
            checks++;
            if (fifo_full !== (i == 7)) begin
                errors++;
                $display("FAIL fill_full[%0d] got %b want %b", i, fifo_full, i == 7);
            end
        end
        wr_en = 1'b0;
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1; data_in = 8'hAA;
            step();
            checks++;
            if (fifo_full !== 1'b1) begin
                errors++; $display("FAIL ovf_full[%0d] got %b want 1", i, fifo_full);
            end
        end
        wr_en = 1'b0;
    endtask

    task automatic test_drain(input logic [7:0] base);
        for (int i = 0; i < 8; i++) begin
            rd_en = 1'b1;
            step();
            checks++;
            if (data_out !== base + 8'(i)) begin
                errors++;
                $display("FAIL drain_data[%0d] got %h want %h", i, data_out, base + 8'(i));
            end
            checks++;
            if (rd_vld !== 1'b1) begin
                errors++; $display("FAIL drain_vld[%0d] got %b want 1", i, rd_vld);
            end
            checks++;
            if (fifo_empty !== (i == 7)) begin
                errors++;
                $display("FAIL drain_empty[%0d] got %b want %b", i, fifo_empty, i == 7);
            end
        end
        step();
        checks++;
        if (rd_vld !== 1'b0) begin
            errors++; $display("FAIL underflow_vld got %b want 0", rd_vld);
        end
        checks++;
        if (data_out !== base + 8'd7) begin
            errors++;
            $display("FAIL underflow_hold got %h want %h", data_out, base + 8'd7);
        end
        rd_en = 1'b0;
    endtask

    task automatic test_simultaneous();
        // Both requests while empty: only the write happens.
        wr_en = 1'b1; rd_en = 1'b1; data_in = 8'h20;
        step();
        checks++;
        if (rd_vld !== 1'b0) begin
            errors++; $display("FAIL empty_both_vld got %b want 0", rd_vld);
        end
        checks++;
        if (fifo_empty !== 1'b0) begin
            errors++; $display("FAIL empty_both_empty got %b want 0", fifo_empty);
        end
        rd_en = 1'b0;
        for (int i = 1; i < 4; i++) begin
            data_in = 8'h20 + 8'(i);
            step();
        end
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1; rd_en = 1'b1; data_in = 8'h24 + 8'(i);
            step();
            checks++;
            if (data_out !== 8'h20 + 8'(i) || rd_vld !== 1'b1) begin
                errors++;
                $display("FAIL both_read[%0d] got %h/%b want %h/1",
                         i, data_out, rd_vld, 8'h20 + 8'(i));
            end
            checks++;
            if (fifo_empty !== 1'b0 || fifo_full !== 1'b0) begin
                errors++;
                $display("FAIL both_flags[%0d] got e%b f%b want e0 f0",
                         i, fifo_empty, fifo_full);
            end
        end
        wr_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rd_en = 1'b1;
            step();
            checks++;
            if (data_out !== 8'h25 + 8'(i) || rd_vld !== 1'b1) begin
                errors++;
                $display("FAIL both_tail[%0d] got %h/%b want %h/1",
                         i, data_out, rd_vld, 8'h25 + 8'(i));
            end
            checks++;
            if (fifo_empty !== (i == 3)) begin
                errors++;
                $display("FAIL both_tail_empty[%0d] got %b want %b", i, fifo_empty, i == 3);
            end
        end
        rd_en = 1'b0;
    endtask

    task automatic test_async_reset();
        wr_en = 1'b1; data_in = 8'h30;
        step();
        data_in = 8'h31;
        step();
        wr_en = 1'b0; rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        checks++;
        if (data_out !== 8'h30 || rd_vld !== 1'b1) begin
            errors++; $display("FAIL pre_rst got %h/%b want 30/1", data_out, rd_vld);
        end
        #2 rstn = 1'b0;
        #1;
        checks++;
        if (fifo_empty !== 1'b1 || fifo_full !== 1'b0) begin
            errors++;
            $display("FAIL async_flags got e%b f%b want e1 f0", fifo_empty, fifo_full);
        end
        checks++;
        if (rd_vld !== 1'b0 || data_out !== 8'h00) begin
            errors++;
            $display("FAIL async_out got %h/%b want 00/0", data_out, rd_vld);
        end
        @(negedge clk);
        rstn = 1'b1;
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        checks++;
        if (rd_vld !== 1'b0 || fifo_empty !== 1'b1) begin
            errors++;
            $display("FAIL post_rst got vld %b e%b want vld 0 e1", rd_vld, fifo_empty);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_fill(8'h00);
        test_overflow();
        test_drain(8'h00);
        test_fill(8'h00);
        test_drain(8'h00);
        test_simultaneous();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
